load_store_unit: RTL and testbench

Sits between the execute stage and the byte-addressed 64-bit data memory. Accepts one load or store request at a time over a valid/ready handshake, checks natural alignment, sign- or zero-extends load data, and performs read-modify-write for sub-doubleword stores. RMW is needed because the data memory always writes all 8 bytes starting at the given address. Returns one response per request, also with valid/ready.

---
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one aligned load or store at a time between execute and 64-bit data memory.
// Latency accept->resp_valid: fault 1, load 2, SD 2, SB/SH/SW 3 (read-modify-write).
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
module load_store_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_read_en,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] rdata_q;
    logic [2:0]      funct3_q;
    logic            store_q;
    logic            fault_q;

    logic [2:0]      align_mask;
    logic            req_fault;

    function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [2:0] f);
        case (f)
            3'b000:  load_extend = {{56{d[7]}},  d[7:0]};
            3'b001:  load_extend = {{48{d[15]}}, d[15:0]};
            3'b010:  load_extend = {{32{d[31]}}, d[31:0]};
            3'b011:  load_extend = d;
            3'b100:  load_extend = {56'b0, d[7:0]};
            3'b101:  load_extend = {48'b0, d[15:0]};
            3'b110:  load_extend = {32'b0, d[31:0]};
            default: load_extend = 64'b0;
        endcase
    endfunction

    // Memory always writes 8 bytes, so keep the upper old bytes and replace the low size bytes.
    function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] w,
                                                input logic [1:0] sz);
        case (sz)
            2'd0:    store_merge = {old[63:8],  w[7:0]};
            2'd1:    store_merge = {old[63:16], w[15:0]};
            2'd2:    store_merge = {old[63:32], w[31:0]};
            default: store_merge = w;
        endcase
    endfunction

    always_comb begin
        align_mask = 3'b000;
        case (req_funct3[1:0])
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        req_fault = (|(req_addr[2:0] & align_mask))
                  | (req_store ? req_funct3[2] : (req_funct3 == 3'b111));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            buf_q    <= '0;
            rdata_q  <= '0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        store_q  <= req_store;
                        buf_q    <= req_wdata;
                        rdata_q  <= '0;
                        fault_q  <= req_fault;
                        if (req_fault)
                            state_q <= RESP;
                        else if (req_store && req_funct3[1:0] == 2'd3)
                            state_q <= WRITE;
                        else
                            state_q <= READ;
                    end
                end
                READ: begin
                    if (store_q) begin
                        buf_q   <= store_merge(mem_read_data, buf_q, funct3_q[1:0]);
                        state_q <= WRITE;
                    end else begin
                        rdata_q <= load_extend(mem_read_data, funct3_q);
                        state_q <= RESP;
                    end
                end
                WRITE: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        rdata_q <= '0;
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESP);
    assign resp_rdata     = rdata_q;
    assign resp_fault     = fault_q;
    assign mem_address    = addr_q;
    assign mem_read_en    = (state_q == READ);
    assign mem_write_en   = (state_q == WRITE);
    assign mem_write_data = (state_q == WRITE) ? buf_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, byte-level reference model, directed and random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [63:0] mem_read_data;

    bit [7:0] mem     [0:127];
    bit [7:0] ref_mem [0:127];

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            mem_read_data[8*i +: 8] = mem[7'(mem_address[6:0] + 7'(i))];
    end

    always @(posedge clk) begin
        if (mem_write_en)
            for (int i = 0; i < 8; i++)
                mem[7'(mem_address[6:0] + 7'(i))] <= mem_write_data[8*i +: 8];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    endtask

    // Issue one request, compare against the byte-level model, optionally stall the response.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int hold);
        int          size;
        logic        exp_fault;
        logic [63:0] exp_rd, exp_wd, wseen, held_rd;
        int          exp_lat, exp_rdc, exp_wrc, lat, rdc, wrc;
        bit          unstable;

        size      = 1 << f3[1:0];
        exp_fault = ((a % size) != 0) || (st ? f3[2] : (f3 == 3'b111));
        exp_rd    = 0;
        exp_wd    = 0;
        if (exp_fault) begin
            exp_lat = 1; exp_rdc = 0; exp_wrc = 0;
        end else if (!st) begin
            exp_lat = 2; exp_rdc = 1; exp_wrc = 0;
            for (int i = 0; i < size; i++)
                exp_rd = exp_rd | (64'(ref_mem[int'(a) + i]) << (8 * i));
            if (!f3[2] && size < 8 && exp_rd[8*size-1])
                exp_rd = exp_rd | ~((64'd1 << (8 * size)) - 64'd1);
        end else begin
            exp_lat = (size == 8) ? 2 : 3;
            exp_rdc = (size == 8) ? 0 : 1;
            exp_wrc = 1;
            for (int i = 0; i < size; i++)
                ref_mem[int'(a) + i] = wd[8*i +: 8];
            for (int i = 0; i < 8; i++)
                exp_wd[8*i +: 8] = ref_mem[int'(a) + i];
        end

        check("req_ready_idle", req_ready, 1'b1);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;

        lat = 1; rdc = 0; wrc = 0; wseen = 0;
        while (!resp_valid && lat < 20) begin
            if (mem_read_en) rdc++;
            if (mem_write_en) begin wrc++; wseen = mem_write_data; end
            @(posedge clk); #1;
            lat++;
        end
        check("resp_valid", resp_valid, 1'b1);
        check("latency", 64'(lat), 64'(exp_lat));
        check("fault", resp_fault, exp_fault);
        check("rdata", resp_rdata, exp_rd);
        check("read_cycles", 64'(rdc), 64'(exp_rdc));
        check("write_cycles", 64'(wrc), 64'(exp_wrc));
        if (exp_wrc != 0) check("write_data", wseen, exp_wd);

        held_rd  = resp_rdata;
        unstable = 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!resp_valid || resp_rdata !== held_rd || req_ready || resp_fault !== exp_fault)
                unstable = 1;
        end
        if (hold > 0) check("hold_stable", 64'(unstable), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("idle_after_hs", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        int          sz;

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_outputs", {resp_valid, resp_fault, mem_read_en, mem_write_en}, 4'b0000);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_mem_addr", mem_address, 64'd0);
        check("rst_mem_wdata", mem_write_data, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Abort a load mid-READ with reset.
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midread_rd_en", mem_read_en, 1'b1);
        rst = 1'b1; #1;
        check("midrst_ready", req_ready, 1'b1);
        check("midrst_outputs", {resp_valid, resp_fault, mem_read_en, mem_write_en}, 4'b0000);
        check("midrst_addr", mem_address, 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 3'b011, 64'h0, 64'h0, 0);

        // Preset bytes 0x10..0x17 then byte loads.
        do_req(1'b1, 3'b011, 64'h10, 64'h0706050403020180, 0);
        do_req(1'b0, 3'b000, 64'h10, 64'h0, 0);
        do_req(1'b0, 3'b100, 64'h10, 64'h0, 0);
        do_req(1'b1, 3'b000, 64'h11, 64'hDEADBEEF000000AA, 0);
        do_req(1'b0, 3'b011, 64'h10, 64'h0, 0);
        check("sb_merged_ld", 64'h070605040302AA80,
              {ref_mem[23], ref_mem[22], ref_mem[21], ref_mem[20],
               ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
        do_req(1'b1, 3'b011, 64'h20, 64'h1122334455667788, 0);
        do_req(1'b0, 3'b011, 64'h20, 64'h0, 0);
        do_req(1'b0, 3'b010, 64'h13, 64'h0, 0);
        do_req(1'b1, 3'b100, 64'h0, 64'h55, 0);
        do_req(1'b0, 3'b001, 64'h10, 64'h0, 5);

        for (int n = 0; n < 80; n++) begin
            f3 = 3'($urandom_range(0, 7));
            sz = 1 << f3[1:0];
            a  = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ~64'(sz - 1);
            do_req(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom},
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
